// File: rtl/flash_audio_player_if.sv
// Bundles the flash Avalon-MM read port and the audio codec write port.
// The player is the master of both; the flash core and codec are the slave.
interface flash_audio_player_if #(
  parameter int ADDR_W = 23
);
  logic              flash_mem_read;
  logic [ADDR_W-1:0] flash_mem_address;
  logic              flash_mem_waitrequest;
  logic [31:0]       flash_mem_readdata;
  logic              flash_mem_readdatavalid;
  logic [3:0]        flash_mem_byteenable;
  logic              write_ready;
  logic              write_s;
  logic [15:0]       writedata_left;
  logic [15:0]       writedata_right;

  modport master (
    output flash_mem_read, flash_mem_address, flash_mem_byteenable,
           write_s, writedata_left, writedata_right,
    input  flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid,
           write_ready
  );

  modport slave (
    input  flash_mem_read, flash_mem_address, flash_mem_byteenable,
           write_s, writedata_left, writedata_right,
    output flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid,
           write_ready
  );
endinterface

// File: rtl/flash_audio_player.sv
// Streams 16-bit PCM from flash to the audio codec, resampled by a Q4.4 phase
// accumulator, with a one-word read cache and loop or one-shot end handling.
module flash_audio_player #(
  parameter int NUM_WORDS   = 1048576,
  parameter int ADDR_W      = 23,
  parameter int ATTEN_SHIFT = 6,
  parameter int STEREO      = 0
) (
  input  logic                 CLOCK_50,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 loop,
  input  logic [7:0]           rate,
  flash_audio_player_if.master bus,
  output logic                 busy,
  output logic                 done
);
  localparam int IDX_W = ADDR_W + 1;
  localparam int POS_W = IDX_W + 4;
  localparam int SAMPLES_INT = (STEREO != 0) ? NUM_WORDS : 2 * NUM_WORDS;
  localparam logic [IDX_W:0] SAMPLES = (IDX_W+1)'(SAMPLES_INT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_FETCH, S_WAIT_DATA, S_WRITE, S_DRAIN, S_ADVANCE
  } state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [3:0]        frac_q;
  logic [31:0]       cache_data_q;
  logic [ADDR_W-1:0] cache_addr_q;
  logic              cache_valid_q;
  logic              read_q;
  logic [ADDR_W-1:0] addr_q;
  logic              write_s_q;
  logic [15:0]       left_q, right_q;
  logic              busy_q, done_q;

  logic [POS_W:0]     nxt_d;
  logic [POS_W-1:0]   wrap_d;
  logic [IDX_W:0]     nxt_idx;
  logic [ADDR_W-1:0]  word_addr;
  logic [15:0]        left_raw, right_raw;
  logic signed [15:0] left_att, right_att;

  // One extra top bit so the compare against the clip length cannot overflow.
  assign nxt_d   = {1'b0, idx_q, frac_q} + {{(POS_W-7){1'b0}}, rate};
  assign nxt_idx = nxt_d[POS_W:4];
  assign wrap_d  = nxt_d[POS_W-1:0] - {SAMPLES[IDX_W-1:0], 4'b0000};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    word_addr = idx_q[ADDR_W-1:0];
    if (STEREO == 0) word_addr = idx_q[ADDR_W:1];
  end

  always_comb begin
    left_raw  = cache_data_q[15:0];
    right_raw = cache_data_q[31:16];
    if (STEREO == 0) begin
      if (idx_q[0]) left_raw = cache_data_q[31:16];
      right_raw = left_raw;
    end
  end

  assign left_att  = $signed(left_raw) >>> ATTEN_SHIFT;
  assign right_att = $signed(right_raw) >>> ATTEN_SHIFT;

  // NOTE: state is updated with non-blocking assignments only, so every branch
  // below reads the values from the start of the cycle.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      frac_q        <= '0;
      // NOTE: the cache is a single word of flops, so it is reset with the
      // rest of the state; a RAM-backed store would not be.
      cache_data_q  <= '0;
      cache_addr_q  <= '0;
      cache_valid_q <= 1'b0;
      read_q        <= 1'b0;
      addr_q        <= '0;
      write_s_q     <= 1'b0;
      left_q        <= '0;
      right_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      write_s_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          idx_q         <= '0;
          frac_q        <= '0;
          cache_valid_q <= 1'b0;
          if (run) begin
            state_q <= S_LOOKUP;
            busy_q  <= 1'b1;
          end
        end
        S_LOOKUP: begin
          if (cache_valid_q && cache_addr_q == word_addr) begin
            state_q <= S_WRITE;
          end else begin
            read_q  <= 1'b1;
            addr_q  <= word_addr;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (!bus.flash_mem_waitrequest) begin
            read_q  <= 1'b0;
            state_q <= S_WAIT_DATA;
          end
        end
        S_WAIT_DATA: begin
          if (bus.flash_mem_readdatavalid) begin
            cache_data_q  <= bus.flash_mem_readdata;
            cache_addr_q  <= addr_q;
            cache_valid_q <= 1'b1;
            state_q       <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (bus.write_ready) begin
            write_s_q <= 1'b1;
            left_q    <= left_att;
            right_q   <= right_att;
            state_q   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The codec must show not-ready before the next sample may go out.
          if (!bus.write_ready) state_q <= S_ADVANCE;
        end
        S_ADVANCE: begin
          if (!run) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (nxt_idx >= SAMPLES && !loop) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (nxt_idx >= SAMPLES) begin
            idx_q   <= wrap_d[POS_W-1:4];
            frac_q  <= wrap_d[3:0];
            state_q <= S_LOOKUP;
          end else begin
            idx_q   <= nxt_d[POS_W-1:4];
            frac_q  <= nxt_d[3:0];
            state_q <= S_LOOKUP;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.flash_mem_read       = read_q;
  assign bus.flash_mem_address    = addr_q;
  assign bus.flash_mem_byteenable = 4'b1111;
  assign bus.write_s              = write_s_q;
  assign bus.writedata_left       = left_q;
  assign bus.writedata_right      = right_q;
  assign busy                     = busy_q;
  assign done                     = done_q;
endmodule
